// File: rtl/uart_pkg.sv
// Shared UART constants and types: receiver state encoding, baud timing
// and the default byte width / receive FIFO depth used by the RX path.
package uart_pkg;

  // Byte width delivered by the receiver and stored by the RX FIFO.
  localparam int unsigned UART_DATA_W     = 8;
  // Default number of entries in the receive FIFO (power of two).
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Baud timing for the receiver.
  localparam int unsigned UART_CLK_HZ       = 50_000_000;
  localparam int unsigned UART_BAUD         = 115_200;
  localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  // Receiver bit-level state machine encoding.
  typedef enum logic [2:0] {
    UART_IDLE    = 3'd0,
    UART_START   = 3'd1,
    UART_DATA    = 3'd2,
    UART_STOP    = 3'd3,
    UART_CLEANUP = 3'd4
  } uart_state_e;

  // Byte handed from the receiver to the FIFO.
  typedef struct packed {
    logic                   valid;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the RX FIFO: DEPTH x DATA_W flops, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk     : system clock
//   wr_en   : write strobe (already qualified by the controller)
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data at rd_addr
module uart_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read gives first-word-fall-through at the top level.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver. First-word-fall-through output
// with a valid/ready read handshake, registered occupancy and flags, and
// a sticky overflow flag for bytes dropped while full.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   wr_data     : received byte
//   wr_en       : byte-valid strobe, one push per cycle while high
//   rd_data     : oldest stored byte (valid while rd_valid)
//   rd_valid    : FIFO not empty
//   rd_ready    : consumer accepts rd_data this cycle
//   count       : occupancy 0..DEPTH
//   full        : count == DEPTH
//   almost_full : count >= AF_LEVEL
//   overflow    : sticky, a byte was dropped
//   ovf_clr     : clear overflow (a simultaneous drop wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = UART_DATA_W,
  parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [PTR_W-1:0] count_n;
  logic             push;
  logic             pop;
  logic             drop;
  logic             empty_n;
  logic             full_n;
  logic             af_n;

  // Handshake qualification and next-pointer / next-flag computation.
  always_comb begin
    pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a write while full is kept.
    push     = wr_en & (~full | pop);
    drop     = wr_en & full & ~pop;
    wr_ptr_n = wr_ptr_q + PTR_W'(push);
    rd_ptr_n = rd_ptr_q + PTR_W'(pop);
    count_n  = wr_ptr_n - rd_ptr_n;
    empty_n  = (wr_ptr_n == rd_ptr_n);
    full_n   = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) &&
               (wr_ptr_n[AW] != rd_ptr_n[AW]);
    af_n     = (count_n >= PTR_W'(AF_LEVEL));
  end

  // Pointers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid    <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_n;
      rd_ptr_q    <= rd_ptr_n;
      rd_valid    <= ~empty_n;
      count       <= count_n;
      full        <= full_n;
      almost_full <= af_n;
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule
